// File: rtl/bram_arbiter.sv
// bram_arbiter: multi-requester front end for one single-port BRAM.
// Combinational one-hot grant (round-robin or fixed priority), lockable
// bursts capped at MAX_BURST beats, and a read-return pipeline that steers
// rvalid back to the issuing port RD_LAT cycles after the read was granted.
module bram_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 1408,
  parameter int RD_LAT    = 2,
  parameter int RR_MODE   = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS-1:0]          lock,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_re,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_data,
  input  logic [DATA_W-1:0]             mem_q
);
  localparam int ID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // per-port views of the flat address/data buses (port i at slice i)
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_a;
  assign addr_a  = addr;
  assign wdata_a = wdata;

  // registered arbitration state
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   owner;
  logic              locked;
  logic [CNT_W-1:0]  cnt;

  // read-return pipeline, tap RD_LAT drives rvalid
  logic [RD_LAT:1]           vld_pipe;
  logic [RD_LAT:1][ID_W-1:0] id_pipe;

  // arbitration results
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic              g_any;
  logic [ID_W-1:0]   g_id;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [ID_W-1:0]   g_inc;
  logic [ID_W-1:0]   owner_inc;
  int                idx;

  // Search requesters starting at ptr (round-robin) or at 0 (fixed priority).
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = ((RR_MODE != 0 ? int'(ptr) : 0) + k) % NUM_PORTS;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Final grant: a lock pins the grant to the owner; reset masks everything.
  // With no grant g_id stays 0 so the memory sees port 0's fields.
  always_comb begin
    g_any = 1'b0;
    g_id  = '0;
    if (rst_n) begin
      if (locked) begin
        g_any = req[owner];
        g_id  = req[owner] ? owner : '0;
      end else begin
        g_any = win_found;
        g_id  = win_id;
      end
    end
  end

  assign cnt_nxt   = cnt + CNT_W'(1);
  assign g_inc     = ID_W'((int'(g_id) + 1) % NUM_PORTS);
  assign owner_inc = ID_W'((int'(owner) + 1) % NUM_PORTS);

  assign mem_we   = g_any & we[g_id];
  assign mem_re   = g_any & ~we[g_id];
  assign mem_addr = addr_a[g_id];
  assign mem_data = wdata_a[g_id];
  assign rdata    = mem_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign gnt[i]    = g_any && (g_id == ID_W'(i));
    assign rvalid[i] = rst_n && vld_pipe[RD_LAT] && (id_pipe[RD_LAT] == ID_W'(i));
  end

  // Lock/pointer bookkeeping: a beat either extends the lock (lock set and
  // cap not yet hit) or releases it; an owner dropping req releases too.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr    <= '0;
      owner  <= '0;
      locked <= 1'b0;
      cnt    <= '0;
    end else if (g_any) begin
      ptr <= g_inc;
      if (lock[g_id] && (cnt_nxt < CNT_W'(MAX_BURST))) begin
        locked <= 1'b1;
        owner  <= g_id;
        cnt    <= cnt_nxt;
      end else begin
        locked <= 1'b0;
        cnt    <= '0;
      end
    end else if (locked) begin
      locked <= 1'b0;
      cnt    <= '0;
      ptr    <= owner_inc;
    end
  end

  // Read-return shift register: each granted read enters at stage 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= g_any & ~we[g_id];
      id_pipe[1]  <= g_id;
      for (int j = 2; j <= RD_LAT; j++) begin
        vld_pipe[j] <= vld_pipe[j-1];
        id_pipe[j]  <= id_pipe[j-1];
      end
    end
  end

endmodule
